// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: captures per-cycle writeback/store activity into a FWFT FIFO,
// tracks run/stall cycles and ends the test on a store to the tohost address or on timeout.
module commit_trace_monitor #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 45000,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              reg_w_rd,
    input  logic [DATA_WIDTH-1:0]   reg_w_data,
    input  logic                    mem_w_valid,
    input  logic [ADDR_WIDTH-1:0]   mem_w_addr,
    input  logic [DATA_WIDTH/8-1:0] mem_w_strb,
    input  logic [DATA_WIDTH-1:0]   mem_w_data,
    input  logic                    stall,
    input  logic                    trace_rden,
    output logic                    trace_valid,
    output logic                    trace_reg_valid,
    output logic [4:0]              trace_rd,
    output logic [DATA_WIDTH-1:0]   trace_reg_data,
    output logic                    trace_mem_valid,
    output logic [ADDR_WIDTH-1:0]   trace_mem_addr,
    output logic [DATA_WIDTH/8-1:0] trace_mem_strb,
    output logic [DATA_WIDTH-1:0]   trace_mem_data,
    output logic [1:0]              state,
    output logic                    timeout,
    output logic [DATA_WIDTH-2:0]   test_num,
    output logic [31:0]             cycle_count,
    output logic [31:0]             stall_count,
    output logic [15:0]             drop_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    // State table:
    //   ST_IDLE | waiting for first start after reset
    //   ST_RUN  | test running, capturing trace and counting cycles
    //   ST_PASS | tohost store with value 1 seen
    //   ST_FAIL | tohost store with other value, or timeout
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic                  reg_valid;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] reg_data;
        logic                  mem_valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB_W-1:0]     strb;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t          state_q, state_d;
    logic            set_timeout, set_test_num;
    logic            tohost_hit, timeout_hit, run_active;
    logic            capture, push, pop, drop, full, empty;
    logic [PTR_W:0]  wr_ptr, rd_ptr;
    entry_t          fifo_mem [FIFO_DEPTH];
    entry_t          new_entry, head;

    assign tohost_hit  = mem_w_valid && (mem_w_addr == TOHOST_ADDR);
    assign timeout_hit = (cycle_count == 32'(TIMEOUT_CYCLES - 1));
    assign run_active  = (state_q == ST_RUN) && !start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        set_timeout  = 1'b0;
        set_test_num = 1'b0;
        if (start) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            // A tohost store outranks a coincident timeout.
            if (tohost_hit) begin
                state_d      = (mem_w_data == DATA_WIDTH'(1)) ? ST_PASS : ST_FAIL;
                set_test_num = 1'b1;
            end else if (timeout_hit) begin
                state_d     = ST_FAIL;
                set_timeout = 1'b1;
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign capture = run_active && ((reg_w_rd != 5'd0) || mem_w_valid);
    assign pop     = trace_rden && !empty;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        new_entry           = '0;
        new_entry.reg_valid = (reg_w_rd != 5'd0);
        new_entry.rd        = reg_w_rd;
        new_entry.reg_data  = (reg_w_rd != 5'd0) ? reg_w_data : '0;
        new_entry.mem_valid = mem_w_valid;
        new_entry.addr      = mem_w_valid ? mem_w_addr : '0;
        new_entry.strb      = mem_w_valid ? mem_w_strb : '0;
        new_entry.data      = mem_w_valid ? mem_w_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cycle_count <= '0;
            stall_count <= '0;
            drop_count  <= '0;
            timeout     <= 1'b0;
            test_num    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            if (state_q == ST_RUN) begin
                cycle_count <= cycle_count + 32'd1;
                if (stall) stall_count <= stall_count + 32'd1;
            end
            if (set_timeout)  timeout  <= 1'b1;
            if (set_test_num) test_num <= mem_w_data[DATA_WIDTH-1:1];
        end
    end

    // Fields read as zero whenever the FIFO is empty, including straight after reset.
    assign head            = empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
    assign trace_valid     = !empty;
    assign trace_reg_valid = head.reg_valid;
    assign trace_rd        = head.rd;
    assign trace_reg_data  = head.reg_data;
    assign trace_mem_valid = head.mem_valid;
    assign trace_mem_addr  = head.addr;
    assign trace_mem_strb  = head.strb;
    assign trace_mem_data  = head.data;
    assign state           = state_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor with a 4-entry FIFO and a 50-cycle timeout.
module tb_commit_trace_monitor;

    logic        clk = 1'b0;
    logic        rst, start, mem_w_valid, stall, trace_rden;
    logic [4:0]  reg_w_rd;
    logic [31:0] reg_w_data, mem_w_addr, mem_w_data;
    logic [3:0]  mem_w_strb;
    logic        trace_valid, trace_reg_valid, trace_mem_valid, timeout;
    logic [4:0]  trace_rd;
    logic [31:0] trace_reg_data, trace_mem_addr, trace_mem_data;
    logic [3:0]  trace_mem_strb;
    logic [1:0]  state;
    logic [30:0] test_num;
    logic [31:0] cycle_count, stall_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_trace_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(50), .TOHOST_ADDR(32'h0000_1000)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .reg_w_rd(reg_w_rd), .reg_w_data(reg_w_data),
        .mem_w_valid(mem_w_valid), .mem_w_addr(mem_w_addr),
        .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data),
        .stall(stall), .trace_rden(trace_rden),
        .trace_valid(trace_valid), .trace_reg_valid(trace_reg_valid),
        .trace_rd(trace_rd), .trace_reg_data(trace_reg_data),
        .trace_mem_valid(trace_mem_valid), .trace_mem_addr(trace_mem_addr),
        .trace_mem_strb(trace_mem_strb), .trace_mem_data(trace_mem_data),
        .state(state), .timeout(timeout), .test_num(test_num),
        .cycle_count(cycle_count), .stall_count(stall_count), .drop_count(drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; reg_w_rd = 0; reg_w_data = 0; mem_w_valid = 0;
        mem_w_addr = 0; mem_w_strb = 0; mem_w_data = 0; stall = 0; trace_rden = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_w_valid = 1; mem_w_addr = addr; mem_w_data = data; mem_w_strb = 4'hF;
        tick(); idle_inputs();
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        reg_w_rd = rd; reg_w_data = data; tick(); idle_inputs();
    endtask

    task automatic pop1();
        trace_rden = 1; tick(); trace_rden = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        chk("rst_state", state, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_testnum", test_num, 0);
        chk("rst_rd", trace_rd, 0);

        // Activity in IDLE is ignored.
        wb(5'd2, 32'h55);
        chk("idle_nocap", trace_valid, 0);
        chk("idle_cycle", cycle_count, 0);

        // Single writeback capture and pop.
        do_start();
        chk("start_state", state, 1);
        chk("start_cycle", cycle_count, 0);
        chk("start_nocap", trace_valid, 0);
        wb(5'd5, 32'h1234);
        chk("wb_valid", trace_valid, 1);
        chk("wb_rd", trace_rd, 5);
        chk("wb_data", trace_reg_data, 32'h1234);
        chk("wb_regv", trace_reg_valid, 1);
        chk("wb_memv", trace_mem_valid, 0);
        pop1();
        chk("wb_popped", trace_valid, 0);
        chk("cycle_2", cycle_count, 2);
        stall = 1; tick(); tick(); tick(); stall = 0;
        chk("stall_cnt", stall_count, 3);
        chk("cycle_5", cycle_count, 5);

        // Passing tohost store after 9 RUN cycles.
        do_start();
        chk("restart_stall", stall_count, 0);
        repeat (9) tick();
        store(32'h1000, 32'h1);
        chk("pass_state", state, 2);
        chk("pass_cycle", cycle_count, 10);
        chk("pass_valid", trace_valid, 1);
        chk("pass_memv", trace_mem_valid, 1);
        chk("pass_addr", trace_mem_addr, 32'h1000);
        chk("pass_mdata", trace_mem_data, 1);
        chk("pass_strb", trace_mem_strb, 4'hF);
        chk("pass_regv", trace_reg_valid, 0);
        store(32'h2000, 32'h99);
        pop1();
        chk("pass_nocap", trace_valid, 0);
        chk("pass_frozen", cycle_count, 10);

        // Failing tohost store combined with a writeback.
        do_start();
        reg_w_rd = 5'd3; reg_w_data = 32'hAA;
        store(32'h1000, 32'h7);
        chk("fail_state", state, 3);
        chk("fail_timeout", timeout, 0);
        chk("fail_testnum", test_num, 3);
        chk("comb_regv", trace_reg_valid, 1);
        chk("comb_rd", trace_rd, 3);
        chk("comb_rdata", trace_reg_data, 32'hAA);
        chk("comb_memv", trace_mem_valid, 1);
        chk("comb_mdata", trace_mem_data, 7);
        pop1();
        chk("comb_single", trace_valid, 0);

        // Timeout after 50 RUN cycles.
        do_start();
        chk("to_restart_testnum", test_num, 0);
        repeat (49) tick();
        chk("to_pre_state", state, 1);
        chk("to_pre_cycle", cycle_count, 49);
        tick();
        chk("to_state", state, 3);
        chk("to_flag", timeout, 1);
        chk("to_cycle", cycle_count, 50);
        tick(); tick();
        chk("to_frozen", cycle_count, 50);

        // Tohost store on the timeout cycle wins.
        do_start();
        chk("to_cleared", timeout, 0);
        repeat (49) tick();
        store(32'h1000, 32'h1);
        chk("race_state", state, 2);
        chk("race_timeout", timeout, 0);
        chk("race_cycle", cycle_count, 50);

        // Overflow, push+pop when full, wrap ordering.
        do_start();
        for (int i = 1; i <= 6; i++) wb(5'(i), 32'h10 + 32'(i));
        chk("ovf_drop", drop_count, 2);
        chk("ovf_head", trace_rd, 1);
        reg_w_rd = 5'd7; reg_w_data = 32'h17; trace_rden = 1; tick(); idle_inputs();
        chk("pp1_drop", drop_count, 2);
        chk("pp1_head", trace_rd, 2);
        reg_w_rd = 5'd8; reg_w_data = 32'h18; trace_rden = 1; tick(); idle_inputs();
        chk("pp2_head", trace_rd, 3);
        chk("pp2_data", trace_reg_data, 32'h13);
        pop1(); chk("wrap_4", trace_rd, 4);
        pop1(); chk("wrap_7", trace_rd, 7);
        chk("wrap_7d", trace_reg_data, 32'h17);
        pop1(); chk("wrap_8", trace_rd, 8);
        pop1(); chk("wrap_empty", trace_valid, 0);
        chk("wrap_zero", trace_rd, 0);
        pop1(); chk("empty_pop", trace_valid, 0);
        wb(5'd9, 32'h19);
        chk("after_pop_rd", trace_rd, 9);
        pop1();
        chk("drop_hold", drop_count, 2);

        // Reset mid-RUN with three entries.
        do_start();
        wb(5'd1, 32'h1); wb(5'd2, 32'h2); wb(5'd3, 32'h3);
        rst = 1; tick(); rst = 0;
        chk("mrst_state", state, 0);
        chk("mrst_valid", trace_valid, 0);
        chk("mrst_cycle", cycle_count, 0);
        chk("mrst_rd", trace_rd, 0);
        do_start();
        wb(5'd5, 32'h1234);
        chk("mrst_wb_rd", trace_rd, 5);
        chk("mrst_wb_data", trace_reg_data, 32'h1234);
        pop1();
        chk("mrst_wb_pop", trace_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
